// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
//   alu_op_e    : 4-bit opcode encoding (12..15 reserved)
//   alu_flags_t : result flags {carry, overflow, zero, negative}
//   alu_state_e : control FSM states
//   updates_cflag(): which opcodes load the carry-chain register
package alu_pkg;

    localparam int unsigned ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_XNOR  = 4'd5,
        OP_SHL   = 4'd6,
        OP_ROR   = 4'd7,
        OP_ADC   = 4'd8,
        OP_SBC   = 4'd9,
        OP_MUL   = 4'd10,
        OP_SRA   = 4'd11,
        OP_RSV12 = 4'd12,
        OP_RSV13 = 4'd13,
        OP_RSV14 = 4'd14,
        OP_RSV15 = 4'd15
    } alu_op_e;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic negative;
    } alu_flags_t;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } alu_state_e;

    localparam alu_flags_t FLAGS_CLEAR = '0;

    // Single-cycle ops whose carry feeds the next ADC/SBC.
    // MUL also loads cflag, but on its completion edge rather than on accept.
    function automatic logic updates_cflag(input alu_op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) || (op == OP_SBC);
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier, one partial product per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load operands and begin (only when not busy)
//   a, b       : WIDTH-bit multiplicand / multiplier
//   busy       : iteration in progress (exactly WIDTH cycles after start)
//   done       : high during the last iteration cycle
//   product    : 2*WIDTH-bit result, valid while done is high (it is the
//                accumulator value after the current step, so the caller
//                can register it on the same edge as the last iteration)
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic               busy_reg;
    logic [CW-1:0]      count_reg;
    logic [WIDTH-1:0]   mcand_reg;
    // Upper half accumulates partial products; lower half starts as the
    // multiplier and is shifted out one bit per step.
    logic [2*WIDTH-1:0] acc_reg;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     partial;
    logic [2*WIDTH-1:0] step_val;

    always_comb begin
        addend   = acc_reg[0] ? mcand_reg : '0;
        partial  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        step_val = {partial, acc_reg[WIDTH-1:1]};
    end

    assign busy    = busy_reg;
    assign done    = busy_reg && (count_reg == CW'(WIDTH - 1));
    assign product = step_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg  <= 1'b0;
            count_reg <= '0;
            mcand_reg <= '0;
            acc_reg   <= '0;
        end else if (start && !busy_reg) begin
            busy_reg  <= 1'b1;
            count_reg <= '0;
            mcand_reg <= a;
            acc_reg   <= {{WIDTH{1'b0}}, b};
        end else if (busy_reg) begin
            acc_reg   <= step_val;
            count_reg <= count_reg + 1'b1;
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith/shift ops plus an
// iterative unsigned multiply, with registered result and flags.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand bundle handshake (a, b, op)
//   out_valid / out_ready: result handshake (y, y_hi, flags)
//   y, y_hi              : result; y_hi is the product high half for MUL
//   carry, overflow, zero, negative : result flags
//   busy                 : multiply in progress
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             busy
);

    localparam int SW = $clog2(WIDTH);

    alu_state_e       state_reg, state_next;
    logic             out_valid_reg, out_valid_next;
    logic [WIDTH-1:0] y_reg, y_next;
    logic [WIDTH-1:0] y_hi_reg, y_hi_next;
    alu_flags_t       flags_reg, flags_next;
    logic             cflag_reg, cflag_next;

    alu_op_e          op_e;
    logic             accept;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [SW-1:0]    sh;
    logic             cin;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] alu_y;
    alu_flags_t       alu_flags;
    alu_flags_t       mul_flags;

    assign op_e      = alu_op_e'(op);
    assign in_ready  = (state_reg == ST_IDLE) && (!out_valid_reg || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op_e == OP_MUL);
    assign sh        = b[SW-1:0];

    // ------------------------------------------------------------------
    // Rotate right as a log-depth barrel: stage gi rotates by 2**gi.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] ror_stage [SW+1];
    assign ror_stage[0] = a;

    for (genvar gi = 0; gi < SW; gi++) begin : g_ror
        localparam int unsigned RS = 2 ** gi;
        assign ror_stage[gi+1] = sh[gi]
            ? {ror_stage[gi][RS-1:0], ror_stage[gi][WIDTH-1:RS]}
            : ror_stage[gi];
    end

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    always_comb begin
        cin      = ((op_e == OP_ADC) || (op_e == OP_SBC)) ? cflag_reg : 1'b0;
        // Subtraction at WIDTH+1 bits: bit WIDTH is the borrow.
        add_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        sub_full = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};

        alu_y          = '0;
        alu_flags      = FLAGS_CLEAR;
        case (op_e)
            OP_ADD, OP_ADC: begin
                alu_y              = add_full[WIDTH-1:0];
                alu_flags.carry    = add_full[WIDTH];
                alu_flags.overflow = (a[WIDTH-1] == b[WIDTH-1]) &&
                                     (add_full[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_SBC: begin
                alu_y              = sub_full[WIDTH-1:0];
                alu_flags.carry    = sub_full[WIDTH];
                alu_flags.overflow = (a[WIDTH-1] != b[WIDTH-1]) &&
                                     (sub_full[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_y = a & b;
            OP_OR:   alu_y = a | b;
            OP_XOR:  alu_y = a ^ b;
            OP_XNOR: alu_y = ~(a ^ b);
            OP_SHL:  alu_y = a << sh;
            OP_ROR:  alu_y = ror_stage[SW];
            OP_SRA:  alu_y = $signed(a) >>> sh;
            // MUL goes through the sequencer; reserved codes yield y = 0.
            default: alu_y = '0;
        endcase
        alu_flags.zero     = (alu_y == '0);
        alu_flags.negative = alu_y[WIDTH-1];
    end

    always_comb begin
        mul_flags          = FLAGS_CLEAR;
        mul_flags.carry    = (mul_product[2*WIDTH-1:WIDTH] != '0);
        mul_flags.zero     = (mul_product == '0);
        mul_flags.negative = mul_product[WIDTH-1];
    end

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    assign busy = mul_busy;

    // ------------------------------------------------------------------
    // Control FSM and output register next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        y_next         = y_reg;
        y_hi_next      = y_hi_reg;
        flags_next     = flags_reg;
        cflag_next     = cflag_reg;
        // A consumed result drops valid unless replaced on this same edge.
        out_valid_next = out_valid_reg && !out_ready;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (op_e == OP_MUL) begin
                        state_next = ST_MUL_BUSY;
                    end else begin
                        y_next         = alu_y;
                        y_hi_next      = '0;
                        flags_next     = alu_flags;
                        out_valid_next = 1'b1;
                        if (updates_cflag(op_e)) begin
                            cflag_next = alu_flags.carry;
                        end
                    end
                end
            end
            ST_MUL_BUSY: begin
                if (mul_done) begin
                    state_next     = ST_IDLE;
                    y_next         = mul_product[WIDTH-1:0];
                    y_hi_next      = mul_product[2*WIDTH-1:WIDTH];
                    flags_next     = mul_flags;
                    cflag_next     = mul_flags.carry;
                    out_valid_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
            y_reg         <= '0;
            y_hi_reg      <= '0;
            flags_reg     <= FLAGS_CLEAR;
            cflag_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= out_valid_next;
            y_reg         <= y_next;
            y_hi_reg      <= y_hi_next;
            flags_reg     <= flags_next;
            cflag_reg     <= cflag_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign y         = y_reg;
    assign y_hi      = y_hi_reg;
    assign carry     = flags_reg.carry;
    assign overflow  = flags_reg.overflow;
    assign zero      = flags_reg.zero;
    assign negative  = flags_reg.negative;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8: a vector table of single-cycle ops
// (applied back-to-back) plus hand-written multiply, backpressure and
// mid-multiply reset sequences.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   op = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] y;
    logic [W-1:0] y_hi;
    logic         carry;
    logic         overflow;
    logic         zero;
    logic         negative;
    logic         busy;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_hi      (y_hi),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected flags are packed as {carry, overflow, zero, negative}.
    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] ey;
        logic [3:0]   ef;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [3:0] o, input logic [W-1:0] aa,
                                input logic [W-1:0] bb, input logic [W-1:0] yy,
                                input logic [3:0] ff);
        vec_t v;
        v.op = o; v.a = aa; v.b = bb; v.ey = yy; v.ef = ff;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_result(input string tag, input logic [W-1:0] ey,
                              input logic [W-1:0] eyhi, input logic [3:0] ef);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".y"}, 32'(y), 32'(ey));
        chk({tag, ".y_hi"}, 32'(y_hi), 32'(eyhi));
        chk({tag, ".flags_cvzn"}, 32'({carry, overflow, zero, negative}), 32'(ef));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                op     a      b      y      cvzn
        vecs[0]  = mk(4'd0,  8'h7F, 8'h01, 8'h80, 4'b0101); // ADD signed overflow
        vecs[1]  = mk(4'd0,  8'hFF, 8'h01, 8'h00, 4'b1010); // ADD carry out, cflag=1
        vecs[2]  = mk(4'd2,  8'hF0, 8'h3C, 8'h30, 4'b0000); // AND leaves cflag alone
        vecs[3]  = mk(4'd8,  8'h00, 8'h00, 8'h01, 4'b0000); // ADC uses cflag=1
        vecs[4]  = mk(4'd1,  8'h00, 8'h01, 8'hFF, 4'b1001); // SUB borrow, cflag=1
        vecs[5]  = mk(4'd9,  8'h05, 8'h01, 8'h03, 4'b0000); // SBC 5-1-1
        vecs[6]  = mk(4'd6,  8'h81, 8'h03, 8'h08, 4'b0000); // SHL
        vecs[7]  = mk(4'd7,  8'h81, 8'h01, 8'hC0, 4'b0001); // ROR
        vecs[8]  = mk(4'd11, 8'h80, 8'h07, 8'hFF, 4'b0001); // SRA negative
        vecs[9]  = mk(4'd13, 8'hFF, 8'hFF, 8'h00, 4'b0010); // reserved
        vecs[10] = mk(4'd3,  8'hF0, 8'h0F, 8'hFF, 4'b0001); // OR
        vecs[11] = mk(4'd4,  8'hAA, 8'hFF, 8'h55, 4'b0000); // XOR
        vecs[12] = mk(4'd5,  8'hAA, 8'h55, 8'h00, 4'b0010); // XNOR
        vecs[13] = mk(4'd1,  8'h80, 8'h01, 8'h7F, 4'b0100); // SUB signed overflow
        vecs[14] = mk(4'd7,  8'h81, 8'h09, 8'hC0, 4'b0001); // ROR uses b[2:0] only
        vecs[15] = mk(4'd11, 8'h40, 8'h02, 8'h10, 4'b0000); // SRA positive
        vecs[16] = mk(4'd0,  8'h80, 8'h80, 8'h00, 4'b1110); // ADD carry+ovf+zero
        vecs[17] = mk(4'd9,  8'h10, 8'h05, 8'h0A, 4'b0000); // SBC with cflag=1

        // Reset
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk("reset.y", 32'(y), 32'd0);
        chk("reset.y_hi", 32'(y_hi), 32'd0);
        chk("reset.flags_cvzn", 32'({carry, overflow, zero, negative}), 32'd0);
        $display("reset: out_valid=%0d busy=%0d in_ready=%0d", out_valid, busy, in_ready);

        // Table of single-cycle ops, issued back to back
        for (int i = 0; i < NV; i++) begin
            op = vecs[i].op; a = vecs[i].a; b = vecs[i].b; in_valid = 1'b1;
            #1;
            chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'd1);
            if (i == 0) chk("vec0.out_valid_before", 32'(out_valid), 32'd0);
            tick();
            chk_result($sformatf("vec%0d", i), vecs[i].ey, '0, vecs[i].ef);
            $display("vec %0d: op=%0d a=%02h b=%02h -> y=%02h cvzn=%b (exp %02h %b)",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, y,
                     {carry, overflow, zero, negative}, vecs[i].ey, vecs[i].ef);
        end
        in_valid = 1'b0;
        tick();
        chk("drain.out_valid", 32'(out_valid), 32'd0);

        // MUL 0xFF x 0xFF
        op = 4'd10; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
        #1;
        chk("mul1.in_ready_accept", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= W; c++) begin
            chk($sformatf("mul1.c%0d.busy", c), 32'(busy), 32'd1);
            chk($sformatf("mul1.c%0d.in_ready", c), 32'(in_ready), 32'd0);
            chk($sformatf("mul1.c%0d.out_valid", c), 32'(out_valid), 32'd0);
            tick();
        end
        chk("mul1.busy_done", 32'(busy), 32'd0);
        chk_result("mul1", 8'h01, 8'hFE, 4'b1000);
        $display("mul FFxFF: y=%02h y_hi=%02h carry=%0d", y, y_hi, carry);

        // ADC 0+0 accepted while consuming the MUL result: cflag must be 1
        op = 4'd8; a = 8'h00; b = 8'h00; in_valid = 1'b1;
        #1;
        chk("adc_after_mul.in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk_result("adc_after_mul", 8'h01, 8'h00, 4'b0000);
        $display("adc after mul: y=%02h", y);

        // Backpressure
        op = 4'd0; a = 8'h11; b = 8'h22; in_valid = 1'b1;
        tick();
        chk_result("bp.add", 8'h33, 8'h00, 4'b0000);
        out_ready = 1'b0;
        op = 4'd4; a = 8'h0F; b = 8'hF0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp.k%0d.in_ready", k), 32'(in_ready), 32'd0);
            chk_result($sformatf("bp.k%0d", k), 8'h33, 8'h00, 4'b0000);
            tick();
        end
        chk_result("bp.held", 8'h33, 8'h00, 4'b0000);
        out_ready = 1'b1;
        #1;
        chk("bp.release.in_ready", 32'(in_ready), 32'd1);
        tick();
        chk_result("bp.xor", 8'hFF, 8'h00, 4'b0001);
        $display("backpressure release: y=%02h", y);

        // New MUL accepted on the same edge the previous result is consumed
        op = 4'd10; a = 8'h0F; b = 8'h10;
        #1;
        chk("mul2.in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("mul2.consumed", 32'(out_valid), 32'd0);
        for (int c = 1; c <= W; c++) begin
            chk($sformatf("mul2.c%0d.busy", c), 32'(busy), 32'd1);
            tick();
        end
        chk_result("mul2", 8'hF0, 8'h00, 4'b0001);
        $display("mul 0Fx10: y=%02h y_hi=%02h", y, y_hi);

        // Reset during cycle 4 of a MUL
        op = 4'd10; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("mrst.busy", 32'(busy), 32'd0);
        chk("mrst.out_valid", 32'(out_valid), 32'd0);
        chk("mrst.in_ready", 32'(in_ready), 32'd1);
        chk("mrst.y", 32'(y), 32'd0);
        chk("mrst.y_hi", 32'(y_hi), 32'd0);
        chk("mrst.flags_cvzn", 32'({carry, overflow, zero, negative}), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("mrst.after%0d.out_valid", c), 32'(out_valid), 32'd0);
            chk($sformatf("mrst.after%0d.busy", c), 32'(busy), 32'd0);
            tick();
        end
        $display("reset mid-mul: busy=%0d out_valid=%0d", busy, out_valid);

        op = 4'd0; a = 8'h02; b = 8'h03; in_valid = 1'b1;
        #1;
        chk("post_rst.in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk_result("post_rst.add", 8'h05, 8'h00, 4'b0000);
        $display("add after reset: y=%02h", y);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 4-bit combinational ALU. Executes one operation at a time on `WIDTH`-bit operands and registers the result and flags. Adds carry-chained arithmetic (ADC/SBC), arithmetic right shift and an iterative unsigned multiply. Sits between the operand-issue logic and the writeback stage; valid/ready on both sides.

## Interface
- `WIDTH`, default 8: operand/result width.
  - Legal values: power of two, ≥ 4.
  - `SW = $clog2(WIDTH)` is the shift-amount width.
- `clk` in 1: single clock; all state is updated on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand bundle valid.
- `in_ready` out 1: block can accept a bundle this cycle.
- `a`, `b` in `WIDTH`: operands.
- `op` in 4: opcode (encoding under Operation).
- `out_valid` out 1: result registers hold an unconsumed result.
- `out_ready` in 1: consumer takes the result this cycle.
- `y` out `WIDTH`: result (low half of the product for MUL).
- `y_hi` out `WIDTH`: high half of the product for MUL; 0 for all other ops.
- `carry`, `overflow`, `zero`, `negative` out 1 each: result flags.
- `busy` out 1: multiply in progress.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB (a−b), 2 AND, 3 OR, 4 XOR, 5 XNOR.
  - 6 SHL: logical left shift of `a` by `b[SW-1:0]`.
  - 7 ROR: rotate `a` right by `b[SW-1:0]`.
  - 8 ADC: a+b+cflag.
  - 9 SBC: a−b−cflag.
  - 10 MUL: unsigned, 2·WIDTH-bit product.
  - 11 SRA: arithmetic right shift of `a` by `b[SW-1:0]`.
  - 12–15 reserved: y=0, y_hi=0, zero=1, all other flags 0.
- Arithmetic is computed at WIDTH+1 bits.
  - ADD/ADC: `carry` = bit WIDTH of the sum.
  - SUB/SBC: `carry` = borrow, i.e. bit WIDTH of the zero-extended difference (1 when a < b + cin).
- `overflow` is signed overflow.
  - ADD/ADC: operand signs equal and result sign differs.
  - SUB/SBC: operand signs differ and result sign differs from `a`.
  - 0 for all other ops.
- MUL:
  - `carry` = (y_hi ≠ 0).
  - `zero` = full 2·WIDTH product is 0.
  - `negative` = y[WIDTH-1].
- Logic, shift and rotate ops: `carry` = 0, `overflow` = 0.
- All ops: `zero` = (y == 0), except MUL as above. `negative` = y[WIDTH-1].
- Internal `cflag` register:
  - Loaded with `carry` when an ADD/SUB/ADC/SBC/MUL result is written.
  - Unchanged by all other ops.
  - ADC/SBC read `cflag` as it stands on their accept edge.
- FSM states: IDLE, MUL_BUSY.
  - IDLE → MUL_BUSY on accept of MUL.
  - MUL_BUSY → IDLE after WIDTH iterations; the result is written on the last iteration edge.
- `in_ready` = (state == IDLE) && (!out_valid || out_ready).
- Accept = in_valid && in_ready. The input bundle is sampled only on the accept edge.
- Output registers hold their value while out_valid && !out_ready.
- `out_valid` clears on the consume edge unless a new result is written on the same edge.

## Timing
- Non-MUL ops: latency 1. The result and out_valid are visible in the cycle after the accept edge.
- Back-to-back non-MUL ops: throughput 1 per cycle while out_ready = 1.
- MUL:
  - `busy` = 1 for exactly WIDTH cycles starting the cycle after accept.
  - out_valid rises WIDTH cycles after the accept edge; the result is visible in cycle WIDTH+1, counting the accept cycle as 0.
  - `in_ready` = 0 throughout.
- A new MUL may be accepted in the same cycle as the previous result is consumed.
- Reset values:
  - out_valid 0, busy 0, in_ready 1.
  - y, y_hi 0; carry, overflow, negative 0; zero 0.
  - cflag 0, state IDLE.
- Reset asserted mid-MUL aborts the operation immediately. No partial result is ever presented.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_e` enum (4-bit, the encodings above).
  - Flag struct `alu_flags_t` {carry, overflow, zero, negative}.
  - Opcode constants.
- Sub-module `alu_mul_seq`:
  - Shift-add multiplier, parametrised by WIDTH.
  - Ports: start, a, b, busy, done, product[2·WIDTH].
- Top level holds the FSM, the combinational datapath for single-cycle ops, cflag and the output registers.

## Test plan
All cases at WIDTH=8.
- ADD 0x7F+0x01 → y=0x80, overflow=1, carry=0, negative=1; out_valid exactly 1 cycle after accept.
- ADD 0xFF+0x01 → y=0x00, carry=1, zero=1; then ADC 0x00+0x00 → y=0x01, carry=0. Then SUB 0x00−0x01 → y=0xFF, carry=1; then SBC 0x05−0x01 → y=0x03.
- Shifts:
  - SHL 0x81 by 3 → 0x08.
  - ROR 0x81 by 1 → 0xC0.
  - SRA 0x80 by 7 → 0xFF.
  - Opcode 13 → y=0, zero=1.
- MUL 0xFF×0xFF → y=0x01, y_hi=0xFE, carry=1.
  - busy high 8 cycles; out_valid 8 cycles after accept.
  - in_ready 0 throughout.
  - cflag=1 afterwards.
- Backpressure: hold out_ready=0 for 3 cycles after a result.
  - y and flags stable; in_ready=0.
  - On release, the next op is accepted the same cycle and its result appears the following cycle.
- Drop rst_n on cycle 4 of a MUL:
  - All outputs go to reset values immediately; in_ready=1 after release.
  - A following ADD 0x02+0x03 → y=0x05.
